regfile_read_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 32-bit, 32-input read mux (register-file read port) among NUM_REQ requesters.

---
 rtl/regfile_read_arbiter_pkg.sv | 20 ++
 rtl/regfile_read_arbiter_rr_pick.sv | 50 +++++
 rtl/regfile_read_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_read_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read-port arbiter.
//   RF_ADDR_W  : mux select / register address width
//   RF_DATA_W  : read data width
//   RF_NUM_REQ : default number of requesters
//   idx_w()    : width of a requester index (never below 1 bit)
package regfile_read_arbiter_pkg;

   localparam int RF_ADDR_W  = 5;
   localparam int RF_DATA_W  = 32;
   localparam int RF_NUM_REQ = 4;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;

   // A single requester still needs a 1-bit pointer/index signal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Rotating-priority picker.
//   elig_i       : eligible requesters
//   ptr_i        : highest-priority index this cycle
//   win_onehot_o : one-hot winner (zero when nothing is eligible)
//   win_idx_o    : binary winner index (don't-care when any_o is low)
//   any_o        : at least one requester eligible
module regfile_read_arbiter_rr_pick
   import regfile_read_arbiter_pkg::*;
#(
   parameter int NUM_REQ = RF_NUM_REQ,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_onehot_o,
   output logic [IDX_W-1:0]   win_idx_o,
   output logic               any_o
);

   localparam logic [IDX_W:0] NUM_REQ_L = (IDX_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     off;
   logic [IDX_W:0]       sum;
   logic                 found;

   always_comb begin
      // Shifting the doubled vector right by ptr puts requester ptr at bit 0,
      // so a plain lowest-set-bit search gives round-robin order.
      dbl   = {elig_i, elig_i} >> ptr_i;
      rot   = dbl[NUM_REQ-1:0];
      off   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            off   = IDX_W'(i);
            found = 1'b1;
         end
      end
      sum = {1'b0, off} + {1'b0, ptr_i};
      if (sum >= NUM_REQ_L) begin
         sum = sum - NUM_REQ_L;
      end
      any_o        = |elig_i;
      win_idx_o    = sum[IDX_W-1:0];
      win_onehot_o = any_o ? (NUM_REQ'(1) << win_idx_o) : '0;
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NUM_REQ
// requesters. Stage 1 registers the winner's grant and address (mux select);
// stage 2 captures the mux output and returns it with a one-hot valid.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : level requests, bit i = requester i
//   addr_i       : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt_o        : registered one-hot grant
//   sel_o        : registered read mux select
//   mux_y_i      : combinational read mux output
//   rdata_o      : registered read data
//   rvalid_o     : registered one-hot data valid
module regfile_read_arbiter
   import regfile_read_arbiter_pkg::*;
#(
   parameter int NUM_REQ = RF_NUM_REQ,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [ADDR_W-1:0]         sel_o,
   input  logic [DATA_W-1:0]         mux_y_i,
   output logic [DATA_W-1:0]         rdata_o,
   output logic [NUM_REQ-1:0]        rvalid_o
);

   localparam int IDX_W = idx_w(NUM_REQ);

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ADDR_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [NUM_REQ-1:0] rvalid_q;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] win_onehot;
   logic [IDX_W-1:0]   win_idx;
   logic               any_win;
   logic [ADDR_W-1:0]  win_addr;

   // Masking the current grant keeps a held request from being served twice
   // before the requester has seen its grant and dropped the request.
   assign elig = req_i & ~gnt_q;

   regfile_read_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .elig_i       (elig),
      .ptr_i        (ptr_q),
      .win_onehot_o (win_onehot),
      .win_idx_o    (win_idx),
      .any_o        (any_win)
   );

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_addr = addr_i[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      gnt_d = win_onehot;
      sel_d = sel_q;
      ptr_d = ptr_q;
      if (any_win) begin
         sel_d = win_addr;
         ptr_d = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
      end
   end

   // RDATA only updates on a data edge, so idle cycles leave the last read visible.
   assign rdata_d = (|gnt_q) ? mux_y_i : rdata_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q    <= '0;
         gnt_q    <= '0;
         sel_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         sel_q    <= sel_d;
         rdata_q  <= rdata_d;
         rvalid_q <= gnt_q;
      end
   end

   assign gnt_o    = gnt_q;
   assign sel_o    = sel_q;
   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter paired with a 32-entry
// register model behind a 32:1 read mux.
module tb_regfile_read_arbiter;

   localparam int NR = 4;
   localparam int AW = 5;
   localparam int DW = 32;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [NR-1:0]    req_i;
   logic [NR*AW-1:0] addr_i;
   logic [NR-1:0]    gnt_o;
   logic [AW-1:0]    sel_o;
   logic [DW-1:0]    mux_y_i;
   logic [DW-1:0]    rdata_o;
   logic [NR-1:0]    rvalid_o;

   logic [DW-1:0] reg_file [32];

   assign mux_y_i = reg_file[sel_o];

   regfile_read_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .addr_i   (addr_i),
      .gnt_o    (gnt_o),
      .sel_o    (sel_o),
      .mux_y_i  (mux_y_i),
      .rdata_o  (rdata_o),
      .rvalid_o (rvalid_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit               pre_rst;
      logic [NR-1:0]    req;
      logic [NR*AW-1:0] addr;
      logic [NR-1:0]    gnt;
      logic [AW-1:0]    sel;
   } vec_t;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   int checks = 0;
   int errors = 0;

   logic [NR-1:0] m_gnt;
   logic [1:0]    m_ptr;
   logic [AW-1:0] m_sel;
   logic [DW-1:0] exp_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_gnt     = '0;
      m_ptr     = '0;
      m_sel     = '0;
      exp_rdata = '0;
      sb_q.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"},    32'(gnt_o),    32'h0);
      check({tag, "_sel"},    32'(sel_o),    32'h0);
      check({tag, "_rdata"},  rdata_o,       32'h0);
      check({tag, "_rvalid"}, 32'(rvalid_o), 32'h0);
   endtask

   // Called at a falling edge; drives one cycle of stimulus and checks the
   // outputs at the following falling edge.
   task automatic cycle(input logic [NR-1:0] req, input logic [NR*AW-1:0] addr);
      logic [NR-1:0] elig;
      logic [NR-1:0] prev_gnt;
      int            w;
      sb_t           e;
      req_i    = req;
      addr_i   = addr;
      prev_gnt = m_gnt;
      elig     = req & ~m_gnt;
      w        = -1;
      for (int k = 0; k < NR; k++) begin
         int c;
         c = (int'(m_ptr) + k) % NR;
         if (w < 0 && elig[c]) w = c;
      end
      if (w >= 0) begin
         m_gnt = NR'(1) << w;
         m_sel = addr[w*AW +: AW];
         m_ptr = 2'((w + 1) % NR);
         sb_q.push_back('{w, reg_file[m_sel]});
      end else begin
         m_gnt = '0;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      check("gnt",    32'(gnt_o),    32'(m_gnt));
      check("sel",    32'(sel_o),    32'(m_sel));
      check("rvalid", 32'(rvalid_o), 32'(prev_gnt));
      if (rvalid_o != '0) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got rvalid %b, expected no data", rvalid_o);
         end else begin
            e = sb_q.pop_front();
            check("rvalid_owner", 32'(rvalid_o), 32'(NR'(1) << e.idx));
            exp_rdata = e.data;
         end
      end
      check("rdata", rdata_o, exp_rdata);
   endtask

   // Called at a falling edge; pulses reset between clock edges.
   task automatic async_reset(input string tag);
      #3 rst_i = 1'b1;
      #1 check_zero({tag, "_during"});
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      @(negedge clk_i);
      model_reset();
      check_zero({tag, "_after"});
   endtask

   task automatic add(input bit pr, input logic [NR-1:0] rq, input logic [NR*AW-1:0] ad,
                      input logic [NR-1:0] g, input logic [AW-1:0] s);
      vecs.push_back('{pr, rq, ad, g, s});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         reg_file[i] = 32'h5A00_0000 | (32'(i) * 32'h0001_0101);
      end
      reg_file[5]  = 32'hDEAD_BEEF;
      reg_file[20] = 32'h1234_5678;
      reg_file[31] = 32'hCAFE_F00D;

      // single read of reg[5]
      add(0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},  4'b0001, 5'd5);
      add(0, 4'b0000, {5'd9, 5'd9, 5'd9, 5'd9},  4'b0000, 5'd5);
      add(0, 4'b0000, {5'd9, 5'd9, 5'd9, 5'd9},  4'b0000, 5'd5);
      // held single request: every other cycle
      for (int i = 0; i < 6; i++) begin
         add(0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, (i % 2 == 0) ? 4'b0001 : 4'b0000, 5'd7);
      end
      // grant left in flight, then reset mid-traffic
      add(0, 4'b0110, {5'd0, 5'd6, 5'd4, 5'd0},  4'b0010, 5'd4);
      // full contention after release starts at requester 0
      add(1, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 4'b0001, 5'd10);
      add(0, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 4'b0010, 5'd11);
      add(0, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 4'b0100, 5'd12);
      add(0, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 4'b1000, 5'd13);
      add(0, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 4'b0001, 5'd10);
      // sparse requests with pointer wrap and address 31
      add(0, 4'b1010, {5'd20, 5'd9, 5'd31, 5'd2}, 4'b0010, 5'd31);
      add(0, 4'b1010, {5'd20, 5'd9, 5'd31, 5'd2}, 4'b1000, 5'd20);
      add(0, 4'b1010, {5'd20, 5'd9, 5'd31, 5'd2}, 4'b0010, 5'd31);
      add(0, 4'b1010, {5'd20, 5'd9, 5'd31, 5'd2}, 4'b1000, 5'd20);
      // idle: grant drops, select and data hold
      add(0, 4'b0000, {5'd1, 5'd1, 5'd1, 5'd1},  4'b0000, 5'd20);
      add(0, 4'b0000, {5'd1, 5'd1, 5'd1, 5'd1},  4'b0000, 5'd20);

      req_i  = '0;
      addr_i = '0;
      rst_i  = 1'b1;
      #1 check_zero("por");
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();

      foreach (vecs[n]) begin
         if (vecs[n].pre_rst) async_reset("rst_traffic");
         cycle(vecs[n].req, vecs[n].addr);
         check($sformatf("vec%0d_gnt", n), 32'(gnt_o), 32'(vecs[n].gnt));
         check($sformatf("vec%0d_sel", n), 32'(sel_o), 32'(vecs[n].sel));
      end
      check("last_rdata", rdata_o, 32'h1234_5678);

      // grant issued, reset before its data edge: the read is dropped
      cycle(4'b0100, {5'd0, 5'd3, 5'd0, 5'd0});
      check("midflight_gnt", 32'(gnt_o), 32'h4);
      async_reset("rst_midflight");
      cycle(4'b0000, '0);
      cycle(4'b0000, '0);
      check("midflight_rvalid", 32'(rvalid_o), 32'h0);
      check("midflight_rdata",  rdata_o,       32'h0);
      check("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 20000");
      $fatal(1);
   end

endmodule
